// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM states, opcodes
// and the aluop encoding understood by the ALU decoder.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        SLTIEX  = 4'd10,
        IMMWB   = 4'd11,
        JEX     = 4'd12
    } statetype;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    // SLTI support is a build-time option, so legality depends on it.
    function automatic logic op_is_legal(input logic [5:0] op, input logic slti_en);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_is_legal = 1'b1;
            OP_SLTI:                                      op_is_legal = slti_en;
            default:                                      op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction
// and drives datapath enables plus aluop for the downstream ALU decoder.
module mips_multicycle_controller
    import mips_pkg::*;
#(
    parameter logic ENABLE_SLTI = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       lord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic [3:0] dbg_state
);

    statetype state_q, state_d, out_state;
    logic     pcwrite, branch;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    assign dbg_state = state_q;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (!op_is_legal(op, ENABLE_SLTI)) state_d = FETCH;
                else begin
                    case (op)
                        OP_LW, OP_SW: state_d = MEMADR;
                        OP_RTYPE:     state_d = RTYPEEX;
                        OP_BEQ:       state_d = BEQEX;
                        OP_ADDI:      state_d = ADDIEX;
                        OP_SLTI:      state_d = SLTIEX;
                        OP_J:         state_d = JEX;
                        default:      state_d = FETCH;
                    endcase
                end
            end
            MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            RTYPEEX: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BEQEX:   state_d = FETCH;
            ADDIEX:  state_d = IMMWB;
            SLTIEX:  state_d = IMMWB;
            IMMWB:   state_d = FETCH;
            JEX:     state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // While reset is held the datapath sees fetch controls, whatever the register holds.
    assign out_state = reset ? FETCH : state_q;

    always_comb begin
        lord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        case (out_state)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = !op_is_legal(op, ENABLE_SLTI);
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   lord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                lord     = 1'b1;
                memwrite = mem_ready;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            SLTIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_SLT;
            end
            IMMWB:   regwrite = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Randomized scoreboard bench for the multicycle controller; one instance with
// SLTI enabled and one without, each held in reset while the other runs.
module tb_mips_multicycle_controller;
    import mips_pkg::*;

    typedef struct packed {
        logic       lord;
        logic       irwrite;
        logic       memwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [1:0] aluop;
        logic       illegal_op;
    } ctrl_t;

    localparam int W = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1, reset2 = 1'b1;
    logic [5:0] op = 6'd0, op2 = 6'd0;
    logic       zero = 1'b0, mem_ready = 1'b0;

    logic       lord1, irwrite1, memwrite1, regdst1, memtoreg1, regwrite1, alusrca1, pcen1, ill1;
    logic [1:0] alusrcb1, pcsrc1, aluop1;
    logic [3:0] dbg_state1;
    logic       lord2, irwrite2, memwrite2, regdst2, memtoreg2, regwrite2, alusrca2, pcen2, ill2;
    logic [1:0] alusrcb2, pcsrc2, aluop2;
    logic [3:0] dbg_state2;
    ctrl_t      a1, a2;

    logic [2*W-1:0] exp_q[$];
    string          tag_q[$];
    int             chk_cnt = 0;
    int             pass_cnt = 0;
    int             act = 1;

    always #5 clk = ~clk;

    mips_multicycle_controller #(.ENABLE_SLTI(1'b1)) dut1 (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .lord(lord1), .irwrite(irwrite1), .memwrite(memwrite1), .regdst(regdst1),
        .memtoreg(memtoreg1), .regwrite(regwrite1), .alusrca(alusrca1), .alusrcb(alusrcb1),
        .pcsrc(pcsrc1), .pcen(pcen1), .aluop(aluop1), .illegal_op(ill1), .dbg_state(dbg_state1)
    );

    mips_multicycle_controller #(.ENABLE_SLTI(1'b0)) dut2 (
        .clk(clk), .reset(reset2), .op(op2), .zero(zero), .mem_ready(mem_ready),
        .lord(lord2), .irwrite(irwrite2), .memwrite(memwrite2), .regdst(regdst2),
        .memtoreg(memtoreg2), .regwrite(regwrite2), .alusrca(alusrca2), .alusrcb(alusrcb2),
        .pcsrc(pcsrc2), .pcen(pcen2), .aluop(aluop2), .illegal_op(ill2), .dbg_state(dbg_state2)
    );

    assign a1 = {lord1, irwrite1, memwrite1, regdst1, memtoreg1, regwrite1, alusrca1,
                 alusrcb1, pcsrc1, pcen1, aluop1, ill1};
    assign a2 = {lord2, irwrite2, memwrite2, regdst2, memtoreg2, regwrite2, alusrca2,
                 alusrcb2, pcsrc2, pcen2, aluop2, ill2};

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic logic [5:0] r6();
        return 6'($urandom_range(63, 0));
    endfunction

    // Reference model: the supported instruction set and the control word of each step.
    function automatic logic legal(input logic [5:0] o, input logic slti_ok);
        return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) || (o == 6'b000100) ||
               (o == 6'b001000) || (o == 6'b000010) || (slti_ok && o == 6'b001010);
    endfunction

    function automatic ctrl_t w_fetch(input logic mr);
        ctrl_t c = '0;
        c.irwrite = mr; c.pcen = mr; c.alusrcb = 2'b01;
        return c;
    endfunction

    function automatic ctrl_t w_decode(input logic ill);
        ctrl_t c = '0;
        c.alusrcb = 2'b11; c.illegal_op = ill;
        return c;
    endfunction

    function automatic ctrl_t w_ex(input logic [1:0] srcb, input logic [1:0] aop);
        ctrl_t c = '0;
        c.alusrca = 1'b1; c.alusrcb = srcb; c.aluop = aop;
        return c;
    endfunction

    function automatic ctrl_t w_mem(input logic wr, input logic mr);
        ctrl_t c = '0;
        c.lord = 1'b1; c.memwrite = wr & mr;
        return c;
    endfunction

    function automatic ctrl_t w_wb(input logic rd, input logic mtr);
        ctrl_t c = '0;
        c.regwrite = 1'b1; c.regdst = rd; c.memtoreg = mtr;
        return c;
    endfunction

    function automatic ctrl_t w_beq(input logic z);
        ctrl_t c = '0;
        c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcen = z;
        return c;
    endfunction

    function automatic ctrl_t w_jump();
        ctrl_t c = '0;
        c.pcsrc = 2'b10; c.pcen = 1'b1;
        return c;
    endfunction

    task automatic cycle(input logic r1, input logic r2, input logic [5:0] o1, input logic [5:0] o2,
                         input logic mr, input logic z, input ctrl_t e1, input ctrl_t e2,
                         input string tag);
        @(posedge clk);
        #1;
        reset = r1; reset2 = r2; op = o1; op2 = o2; mem_ready = mr; zero = z;
        exp_q.push_back({e1, e2});
        tag_q.push_back(tag);
    endtask

    // One cycle on the active instance; the idle one sits in reset showing fetch controls.
    task automatic step(input logic [5:0] o, input logic mr, input logic z, input ctrl_t e,
                        input string tag);
        if (act == 1) cycle(1'b0, 1'b1, o, r6(), mr, z, e, w_fetch(mr), tag);
        else          cycle(1'b1, 1'b0, r6(), o, mr, z, w_fetch(mr), e, tag);
    endtask

    task automatic do_reset(input int n);
        logic mr;
        for (int i = 0; i < n; i++) begin
            mr = rb();
            cycle(1'b1, 1'b1, r6(), r6(), mr, rb(), w_fetch(mr), w_fetch(mr), "reset");
        end
    endtask

    task automatic run_instr(input logic [5:0] o, input logic z, input int wf, input int wm);
        logic ok;
        ok = legal(o, act == 1);
        for (int i = 0; i < wf; i++) step(r6(), 1'b0, rb(), w_fetch(1'b0), "fetch_wait");
        step(r6(), 1'b1, rb(), w_fetch(1'b1), "fetch");
        step(o, rb(), rb(), w_decode(!ok), "decode");
        if (!ok) return;
        if (o == 6'b100011 || o == 6'b101011) begin
            step(o, rb(), rb(), w_ex(2'b10, 2'b00), "memadr");
            for (int i = 0; i < wm; i++) step(o, 1'b0, rb(), w_mem(o[3], 1'b0), "mem_wait");
            step(o, 1'b1, rb(), w_mem(o[3], 1'b1), "mem");
            if (o == 6'b100011) step(o, rb(), rb(), w_wb(1'b0, 1'b1), "memwb");
        end else if (o == 6'b000000) begin
            step(o, rb(), rb(), w_ex(2'b00, 2'b10), "rtypeex");
            step(o, rb(), rb(), w_wb(1'b1, 1'b0), "aluwb");
        end else if (o == 6'b000100) begin
            step(o, rb(), z, w_beq(z), "beqex");
        end else if (o == 6'b001000 || o == 6'b001010) begin
            step(o, rb(), rb(), w_ex(2'b10, (o == 6'b001010) ? 2'b11 : 2'b00), "immex");
            step(o, rb(), rb(), w_wb(1'b0, 1'b0), "immwb");
        end else begin
            step(o, rb(), rb(), w_jump(), "jex");
        end
    endtask

    task automatic run_random(input int n);
        logic [5:0] ops [8];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b001010, 6'b000010, 6'b111111};
        for (int i = 0; i < n; i++) begin
            logic [5:0] o;
            o = ops[$urandom_range(7, 0)];
            if (o == 6'b111111) o = r6();
            run_instr(o, rb(), $urandom_range(2, 0), $urandom_range(2, 0));
        end
    endtask

    initial begin : monitor
        logic [2*W-1:0] e;
        string          t;
        logic           r1_prev, r2_prev;
        r1_prev = 1'b0;
        r2_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (r1_prev) begin
                chk_cnt++;
                if (dbg_state1 == FETCH) pass_cnt++;
                else $display("FAIL state_after_reset dut1: got %0d want %0d", dbg_state1, FETCH);
            end
            if (r2_prev) begin
                chk_cnt++;
                if (dbg_state2 == FETCH) pass_cnt++;
                else $display("FAIL state_after_reset dut2: got %0d want %0d", dbg_state2, FETCH);
            end
            r1_prev = reset;
            r2_prev = reset2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                chk_cnt += 2;
                if (a1 === e[2*W-1:W]) pass_cnt++;
                else $display("FAIL %s dut1 @%0t: got %h want %h", t, $time, a1, e[2*W-1:W]);
                if (a2 === e[W-1:0]) pass_cnt++;
                else $display("FAIL %s dut2 @%0t: got %h want %h", t, $time, a2, e[W-1:0]);
            end
        end
    end

    initial begin : driver
        act = 1;
        do_reset(2);
        run_instr(6'b100011, 1'b0, 0, 0);
        run_instr(6'b101011, 1'b0, 1, 2);
        run_instr(6'b000100, 1'b1, 0, 0);
        run_instr(6'b000100, 1'b0, 0, 0);
        run_instr(6'b000000, 1'b0, 0, 0);
        run_instr(6'b001000, 1'b0, 0, 0);
        run_instr(6'b001010, 1'b0, 0, 0);
        run_instr(6'b111111, 1'b0, 0, 0);
        run_instr(6'b000010, 1'b0, 0, 0);
        // lw interrupted by reset while the read is still pending
        step(r6(), 1'b1, 1'b0, w_fetch(1'b1), "fetch");
        step(6'b100011, 1'b1, 1'b0, w_decode(1'b0), "decode");
        step(6'b100011, 1'b1, 1'b0, w_ex(2'b10, 2'b00), "memadr");
        step(6'b100011, 1'b0, 1'b0, w_mem(1'b0, 1'b0), "memrd_wait");
        cycle(1'b1, 1'b1, 6'b100011, r6(), 1'b0, 1'b0, w_fetch(1'b0), w_fetch(1'b0), "reset_memrd");
        run_instr(6'b100011, 1'b1, 0, 1);
        run_random(50);

        act = 2;
        run_instr(6'b001010, 1'b0, 0, 0);
        run_instr(6'b001000, 1'b0, 0, 0);
        run_instr(6'b001010, 1'b0, 1, 0);
        run_random(20);

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
